// File: rtl/reg_access_ctrl.sv
// Request/response sequencer for a bank of storage registers.
// Converts single read/write requests into phased cs/w/r strobes and returns read data.
module reg_access_ctrl #(
    parameter int DATA_W = 16,
    parameter int NREG   = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] reg_din,
    output logic [NREG-1:0]   reg_cs,
    output logic              reg_w,
    output logic              reg_r,
    input  logic [DATA_W-1:0] reg_dout
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        ACCESS  = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t state;
    logic   we_q;

    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] a);
        onehot = '0;
        for (int i = 0; i < NREG; i++)
            if (a == ADDR_W'(i)) onehot[i] = 1'b1;
    endfunction

    // All outputs are registered; each state's outputs are loaded on the edge entering it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            we_q      <= 1'b0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            reg_din   <= '0;
            reg_cs    <= '0;
            reg_w     <= 1'b0;
            reg_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        if (int'(req_addr) >= NREG) begin
                            // Out-of-range address: respond immediately, never touch the bank.
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else begin
                            state   <= SETUP;
                            reg_cs  <= onehot(req_addr);
                            reg_din <= req_we ? req_wdata : '0;
                        end
                    end
                end
                SETUP: begin
                    state <= ACCESS;
                    reg_w <= we_q;
                    reg_r <= !we_q;
                end
                ACCESS: begin
                    reg_w <= 1'b0;
                    if (we_q) begin
                        state     <= RESP;
                        reg_cs    <= '0;
                        reg_din   <= '0;
                        reg_r     <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end else begin
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // Read strobe held one more cycle so DOut has settled before capture.
                    state     <= RESP;
                    rsp_rdata <= reg_dout;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    reg_cs    <= '0;
                    reg_din   <= '0;
                    reg_r     <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                    reg_din   <= '0;
                    reg_cs    <= '0;
                    reg_w     <= 1'b0;
                    reg_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Bench for reg_access_ctrl: directed scenarios then random traffic against a
// transaction-level expectation of strobe timing and register contents.
module tb_reg_access_ctrl;

    localparam int DATA_W = 16;
    localparam int NREG   = 3;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [DATA_W-1:0] rsp_rdata, reg_din, reg_dout;
    logic [NREG-1:0]   reg_cs;
    logic              reg_w, reg_r;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] bank    [NREG];
    logic [DATA_W-1:0] exp_mem [NREG];

    always #5 clk = ~clk;

    reg_access_ctrl #(.DATA_W(DATA_W), .NREG(NREG), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .reg_din(reg_din), .reg_cs(reg_cs), .reg_w(reg_w), .reg_r(reg_r),
        .reg_dout(reg_dout)
    );

    // Attached register bank with externally muxed DOut.
    always @(posedge clk)
        if (reg_w)
            for (int i = 0; i < NREG; i++)
                if (reg_cs[i]) bank[i] <= reg_din;

    always_comb begin
        reg_dout = '0;
        for (int i = 0; i < NREG; i++)
            if (reg_cs[i]) reg_dout = bank[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp"}, {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk({tag, "_reg"}, {reg_din, reg_cs, reg_w, reg_r}, 0);
    endtask

    // One full transaction; expectations follow from the phase rules:
    // SETUP, ACCESS, (CAPTURE for reads), then RESP held for 'stall' cycles.
    task automatic txn(input logic we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input int stall);
        logic              err;
        int                lat, cs_last;
        logic [DATA_W-1:0] exp_rd;
        logic [31:0]       exp_cs;
        err     = (int'(addr) >= NREG);
        lat     = err ? 1 : (we ? 3 : 4);
        cs_last = err ? 0 : (we ? 2 : 3);
        exp_rd  = (!err && !we) ? exp_mem[addr] : '0;
        exp_cs  = 32'(1) << addr;
        chk("accept_ready", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        cyc();
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = ADDR_W'($urandom);
        req_wdata = DATA_W'($urandom);
        for (int k = 1; k <= lat; k++) begin
            if (k > 1) cyc();
            chk("cs",       reg_cs, (k <= cs_last) ? exp_cs : 0);
            chk("w",        reg_w, 32'(!err && we && k == 2));
            chk("r",        reg_r, 32'(!err && !we && (k == 2 || k == 3)));
            chk("din",      reg_din, (!err && we && k <= 2) ? 32'(wd) : 0);
            chk("busy",     req_ready, 0);
            chk("rsp_valid", rsp_valid, 32'(k == lat));
            if (k < lat) rsp_ready = 1'($urandom);
        end
        chk("rsp_err", rsp_err, 32'(err));
        chk("rsp_rdata", rsp_rdata, 32'(exp_rd));
        if (!err && we) begin
            exp_mem[addr] = wd;
            chk("bank_wr", bank[addr], 32'(exp_mem[addr]));
        end
        for (int s = 0; s < stall; s++) begin
            rsp_ready = 1'b0;
            cyc();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", {rsp_err, rsp_rdata}, {err, exp_rd});
            chk("stall_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        cyc();
        chk("done_valid", rsp_valid, 0);
        chk("done_ready", req_ready, 1);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            bank[i]    = '0;
            exp_mem[i] = '0;
        end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; rsp_ready = 1'b1;
        @(negedge clk);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_quiet("idle");
            cyc();
        end

        txn(1'b1, 2'd1, 16'd325, 0);
        chk("model_r1", bank[1], 325);
        txn(1'b1, 2'd2, 16'd724, 0);
        txn(1'b0, 2'd2, 16'd0, 0);
        txn(1'b0, 2'd1, 16'd0, 5);
        txn(1'b0, 2'd3, 16'hBEEF, 0);
        txn(1'b1, 2'd3, 16'hBEEF, 2);

        // Reset while a write to register 0 is in its ACCESS cycle.
        req_valid = 1'b1; req_we = 1'b1; req_addr = 2'd0; req_wdata = 16'h5A5A;
        cyc();
        req_valid = 1'b0;
        cyc();
        chk("abort_access_w", reg_w, 1);
        rst = 1'b1;
        cyc();
        // The bank saw w/cs high on the reset edge, so the write landed.
        exp_mem[0] = 16'h5A5A;
        chk_quiet("abort");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_quiet("post_abort");
        end
        txn(1'b0, 2'd0, 16'd0, 0);

        for (int n = 0; n < 40; n++)
            txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0);

        for (int i = 0; i < NREG; i++)
            chk("final_bank", bank[i], 32'(exp_mem[i]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
